// File: rtl/i2c_bus_arb.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ requesters, with bus lock and inter-transaction gap.
// Optional WAIT-state watchdog with mst_abort is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arb #(
  parameter int          NUM_REQ        = 3,
  parameter logic [31:0] I2C_TXN_DELAY  = 32'd20,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [7*NUM_REQ-1:0] req_slave,
  input  logic [8*NUM_REQ-1:0] req_reg,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [7:0]           rdata,
  output logic                 nack,
  output logic                 err,
  output logic                 mst_start,
  output logic                 mst_rw,
  output logic [6:0]           mst_slave,
  output logic [7:0]           mst_reg,
  output logic [7:0]           mst_wdata,
  output logic                 mst_abort,
  input  logic                 mst_busy,
  input  logic                 mst_done,
  input  logic [7:0]           mst_rdata,
  input  logic                 mst_nack,
  output logic [2:0]           dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] lock_idx;
  logic             lock_valid;
  logic [31:0]      gap_cnt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic [PTR_W-1:0] cand_idx;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0]      wd_cnt;
`endif

  assign dbg_state = state;

  // Handshake: a requester holds req and its operands stable from assertion until its
  // one-clock req_done pulse; gnt names the owner, and only the owner sees req_done.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr;
    cand_idx   = rr_ptr;
    if (lock_valid && req[lock_idx]) begin
      pick_valid = 1'b1;
      pick_idx   = lock_idx;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!pick_valid && req[cand_idx]) begin
          pick_valid = 1'b1;
          pick_idx   = cand_idx;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      owner_idx  <= '0;
      lock_idx   <= '0;
      lock_valid <= 1'b0;
      gap_cnt    <= '0;
      gnt        <= '0;
      req_done   <= '0;
      rdata      <= '0;
      nack       <= 1'b0;
      mst_start  <= 1'b0;
      mst_rw     <= 1'b0;
      mst_slave  <= '0;
      mst_reg    <= '0;
      mst_wdata  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      err        <= 1'b0;
      mst_abort  <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      mst_start <= 1'b0;
      req_done  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      mst_abort <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // A locked owner that has let go of req gives the bus back to round-robin.
          if (lock_valid && !req[lock_idx]) lock_valid <= 1'b0;
          if (pick_valid) begin
            owner_idx <= pick_idx;
            gnt       <= ONE_HOT0 << pick_idx;
            mst_rw    <= req_rw[pick_idx];
            mst_slave <= req_slave[int'(pick_idx)*7 +: 7];
            mst_reg   <= req_reg[int'(pick_idx)*8 +: 8];
            mst_wdata <= req_wdata[int'(pick_idx)*8 +: 8];
            state     <= S_ISSUE;
          end else begin
            gnt <= '0;
          end
        end
        S_ISSUE: begin
          if (!mst_busy) begin
            mst_start <= 1'b1;
            state     <= S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (mst_done) begin
            rdata    <= mst_rdata;
            nack     <= mst_nack;
            req_done <= gnt;
            state    <= S_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
            err      <= 1'b0;
          end else if (wd_cnt == TIMEOUT_CYCLES - 32'd1) begin
            mst_abort <= 1'b1;
            rdata     <= '0;
            nack      <= 1'b0;
            err       <= 1'b1;
            req_done  <= gnt;
            state     <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
`endif
          end
        end
        S_DONE: begin
          rr_ptr     <= (owner_idx == LAST_IDX) ? '0 : owner_idx + PTR_W'(1);
          lock_valid <= lock[owner_idx];
          lock_idx   <= owner_idx;
          gap_cnt    <= '0;
          if (!lock[owner_idx]) gnt <= '0;
          state <= (I2C_TXN_DELAY == 32'd0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == I2C_TXN_DELAY - 32'd1) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 32'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef I2C_ARB_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err       = 1'b0;
  assign mst_abort = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arb.sv
// Directed bench for i2c_bus_arb: table of single transactions plus hand sequences for
// contention, lock, gap spacing, reset in WAIT and (with I2C_ARB_TIMEOUT_EN) watchdog abort.
module tb_i2c_bus_arb;

  logic        clock;
  logic        reset;
  logic [2:0]  req, lock, req_rw;
  logic [20:0] req_slave;
  logic [23:0] req_reg, req_wdata;
  logic [2:0]  gnt, req_done;
  logic [7:0]  rdata;
  logic        nack, err;
  logic        mst_start, mst_rw, mst_abort;
  logic [6:0]  mst_slave;
  logic [7:0]  mst_reg, mst_wdata;
  logic        mst_busy, mst_done, mst_nack;
  logic [7:0]  mst_rdata;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_bus_arb #(
    .NUM_REQ(3), .I2C_TXN_DELAY(32'd20), .TIMEOUT_CYCLES(32'd50)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .lock(lock), .req_rw(req_rw),
    .req_slave(req_slave), .req_reg(req_reg), .req_wdata(req_wdata),
    .gnt(gnt), .req_done(req_done), .rdata(rdata), .nack(nack), .err(err),
    .mst_start(mst_start), .mst_rw(mst_rw), .mst_slave(mst_slave),
    .mst_reg(mst_reg), .mst_wdata(mst_wdata), .mst_abort(mst_abort),
    .mst_busy(mst_busy), .mst_done(mst_done), .mst_rdata(mst_rdata),
    .mst_nack(mst_nack), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // exactly zero or one grant bit at every sample point
  always @(negedge clock) begin
    if (!reset) check("gnt_at_most_one", ($countones(gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
  end

  // driver tasks
  task automatic clear_inputs();
    req = '0; lock = '0; req_rw = '0;
    req_slave = '0; req_reg = '0; req_wdata = '0;
    mst_busy = 1'b0; mst_done = 1'b0; mst_rdata = '0; mst_nack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_ops(input int idx, input logic rw, input logic [6:0] sl,
                         input logic [7:0] rg, input logic [7:0] wd);
    req_rw[idx] = rw;
    req_slave[idx*7 +: 7] = sl;
    req_reg[idx*8 +: 8] = rg;
    req_wdata[idx*8 +: 8] = wd;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (dbg_state != 3'd0 && c < 60) begin
      @(negedge clock);
      c++;
    end
    check("idle_reached", {29'd0, dbg_state}, 32'd0);
  endtask

  // waits for a start, completes it with a one-clock mst_done and returns at the DONE sample
  task automatic serve_one(output int owner);
    int c = 0;
    owner = -1;
    while (mst_start !== 1'b1 && c < 60) begin
      @(negedge clock);
      c++;
    end
    check("start_seen", {31'd0, mst_start}, 32'd1);
    check("gnt_onehot", $countones(gnt), 32'd1);
    for (int i = 0; i < 3; i++) if (gnt[i]) owner = i;
    mst_done = 1'b1; mst_rdata = 8'h5A;
    @(negedge clock);
    mst_done = 1'b0;
    check("serve_req_done", {29'd0, req_done}, {29'd0, gnt});
  endtask

  typedef struct {
    int         idx;
    logic       rw;
    logic [6:0] slave;
    logic [7:0] rg;
    logic [7:0] wdata;
    logic [7:0] m_rdata;
    logic       m_nack;
    int         busy;
    logic [2:0] exp_gnt;
    logic [7:0] exp_rdata;
    logic       exp_nack;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v);
    @(negedge clock);
    mst_busy = (v.busy > 0);
    set_ops(v.idx, v.rw, v.slave, v.rg, v.wdata);
    req[v.idx] = 1'b1;
    @(negedge clock);
    check("grant", {29'd0, gnt}, {29'd0, v.exp_gnt});
    check("start_early", {31'd0, mst_start}, 32'd0);
    if (v.busy > 0) begin
      repeat (v.busy) begin
        @(negedge clock);
        check("start_while_busy", {31'd0, mst_start}, 32'd0);
      end
      mst_busy = 1'b0;
    end
    @(negedge clock);
    check("start_pulse", {31'd0, mst_start}, 32'd1);
    check("mst_rw", {31'd0, mst_rw}, {31'd0, v.rw});
    check("mst_slave", {25'd0, mst_slave}, {25'd0, v.slave});
    check("mst_reg", {24'd0, mst_reg}, {24'd0, v.rg});
    check("mst_wdata", {24'd0, mst_wdata}, {24'd0, v.wdata});
    @(negedge clock);
    check("start_single", {31'd0, mst_start}, 32'd0);
    mst_done = 1'b1; mst_rdata = v.m_rdata; mst_nack = v.m_nack;
    @(negedge clock);
    mst_done = 1'b0; mst_nack = 1'b0;
    check("req_done", {29'd0, req_done}, {29'd0, v.exp_gnt});
    check("rdata", {24'd0, rdata}, {24'd0, v.exp_rdata});
    check("nack", {31'd0, nack}, {31'd0, v.exp_nack});
    check("err", {31'd0, err}, 32'd0);
    req[v.idx] = 1'b0;
    @(negedge clock);
    check("req_done_single", {29'd0, req_done}, 32'd0);
    check("gnt_gap_unlocked", {29'd0, gnt}, 32'd0);
    check("rdata_held", {24'd0, rdata}, {24'd0, v.exp_rdata});
    wait_idle();
  endtask

  initial begin
    int o;
    int c;
    //            idx rw slave  reg    wdata  m_rd   nack busy gnt     rdata  nack
    vecs[0] = '{0, 1'b0, 7'h39, 8'h41, 8'h10, 8'h00, 1'b0, 0, 3'b001, 8'h00, 1'b0};
    vecs[1] = '{1, 1'b1, 7'h39, 8'h9A, 8'h00, 8'h03, 1'b0, 0, 3'b010, 8'h03, 1'b0};
    vecs[2] = '{2, 1'b0, 7'h3C, 8'h55, 8'hA5, 8'h00, 1'b1, 5, 3'b100, 8'h00, 1'b1};
    vecs[3] = '{0, 1'b1, 7'h21, 8'h07, 8'h00, 8'hC3, 1'b0, 0, 3'b001, 8'hC3, 1'b0};

    do_reset();
    @(negedge clock);
    check("rst_gnt", {29'd0, gnt}, 32'd0);
    check("rst_req_done", {29'd0, req_done}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_nack_err", {30'd0, nack, err}, 32'd0);
    check("rst_start_abort", {30'd0, mst_start, mst_abort}, 32'd0);
    check("rst_mst_ops", {7'd0, mst_rw, mst_slave, mst_reg, mst_wdata}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // back-to-back from one requester: gap spacing between starts
    do_reset();
    set_ops(1, 1'b1, 7'h39, 8'h9A, 8'h00);
    req[1] = 1'b1;
    serve_one(o);
    check("gap_owner", o, 32'd1);
    c = 0;
    while (mst_start !== 1'b1 && c < 60) begin
      @(negedge clock);
      c++;
    end
    check("gap_spacing", (c >= 21 && c <= 23) ? 32'd1 : 32'd0, 32'd1);
    serve_one(o);
    req = '0;
    @(negedge clock);
    wait_idle();

    // contention: grant order 0,1,2,0
    do_reset();
    for (int i = 0; i < 3; i++) set_ops(i, 1'b0, 7'h10 + 7'(i), 8'(i), 8'(i));
    req = 3'b111;
    serve_one(o); check("rr_order_0", o, 32'd0);
    serve_one(o); check("rr_order_1", o, 32'd1);
    serve_one(o); check("rr_order_2", o, 32'd2);
    serve_one(o); check("rr_order_3", o, 32'd0);
    req = '0;
    @(negedge clock);
    wait_idle();

    // lock: requester 0 twice, then requester 1
    do_reset();
    set_ops(0, 1'b0, 7'h39, 8'h01, 8'h11);
    set_ops(1, 1'b0, 7'h39, 8'h02, 8'h22);
    req = 3'b011; lock = 3'b001;
    serve_one(o); check("lock_first", o, 32'd0);
    @(negedge clock);
    check("gnt_gap_locked", {29'd0, gnt}, 32'b001);
    lock = 3'b000;
    serve_one(o); check("lock_second", o, 32'd0);
    @(negedge clock);
    check("gnt_gap_released", {29'd0, gnt}, 32'd0);
    serve_one(o); check("lock_then_rr", o, 32'd1);
    req = '0;
    @(negedge clock);
    wait_idle();

    // reset while waiting on the master, then a stray mst_done in IDLE
    do_reset();
    set_ops(0, 1'b1, 7'h39, 8'h41, 8'h10);
    req = 3'b001;
    c = 0;
    while (mst_start !== 1'b1 && c < 10) begin
      @(negedge clock);
      c++;
    end
    check("wait_start", {31'd0, mst_start}, 32'd1);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_gnt", {29'd0, gnt}, 32'd0);
    check("async_rst_state", {29'd0, dbg_state}, 32'd0);
    check("async_rst_ops", {7'd0, mst_rw, mst_slave, mst_reg, mst_wdata}, 32'd0);
    @(negedge clock);
    req = '0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("no_done_after_rst", {29'd0, req_done}, 32'd0);
      check("no_abort_after_rst", {31'd0, mst_abort}, 32'd0);
    end
    mst_done = 1'b1; mst_rdata = 8'hAA;
    @(negedge clock);
    mst_done = 1'b0;
    @(negedge clock);
    check("stray_done_ignored", {29'd0, req_done}, 32'd0);
    check("stray_rdata_ignored", {24'd0, rdata}, 32'd0);
    check("stray_state", {29'd0, dbg_state}, 32'd0);

`ifdef I2C_ARB_TIMEOUT_EN
    // watchdog: no mst_done ever arrives
    do_reset();
    set_ops(0, 1'b1, 7'h39, 8'h41, 8'h10);
    req = 3'b001;
    c = 0;
    while (mst_start !== 1'b1 && c < 10) begin
      @(negedge clock);
      c++;
    end
    c = 0;
    while (mst_abort !== 1'b1 && c < 80) begin
      @(negedge clock);
      c++;
    end
    check("abort_latency", c, 32'd50);
    check("abort_req_done", {29'd0, req_done}, 32'b001);
    check("abort_err", {31'd0, err}, 32'd1);
    check("abort_nack_rdata", {23'd0, nack, rdata}, 32'd0);
    req = '0;
    @(negedge clock);
    check("abort_single", {31'd0, mst_abort}, 32'd0);
    wait_idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arb.md
Name: i2c_bus_arb

Overview:
- Shares one i2c_master between up to NUM_REQ requesters, e.g. adv7513_init, adv7513_reg_read and a future camera-sensor config block.
- Round-robin arbitration, optional bus lock for multi-transaction sequences, and an enforced inter-transaction gap.
- Sits between the requester FSMs and i2c_master in cam_test; the only block that drives the master's start.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- I2C_TXN_DELAY, 32'd20, idle clocks between a completed transaction and the next start.
- TIMEOUT_CYCLES, 32'd100000, WAIT-state watchdog limit (used only with I2C_ARB_TIMEOUT_EN).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester transaction request, level.
- lock  in  NUM_REQ  hold bus after current transaction.
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_slave  in  7*NUM_REQ  slave address; requester i uses bits [7i+6:7i].
- req_reg  in  8*NUM_REQ  register address; requester i uses [8i+7:8i].
- req_wdata  in  8*NUM_REQ  write data.
- gnt  out  NUM_REQ  one-hot, the current owner.
- req_done  out  NUM_REQ  one-clock completion pulse to the owner.
- rdata  out  8  read data, valid with req_done.
- nack  out  1  slave NACK, valid with req_done.
- err  out  1  timeout flag, valid with req_done.
- mst_start  out  1  one-clock start pulse to i2c_master.
- mst_rw  out  1  latched transaction direction.
- mst_slave  out  7  latched slave address.
- mst_reg  out  8  latched register address.
- mst_wdata  out  8  latched write data.
- mst_abort  out  1  one-clock abort pulse to i2c_master.
- mst_busy  in  1  master busy.
- mst_done  in  1  master completion pulse.
- mst_rdata  in  8  master read data.
- mst_nack  in  1  master NACK status.

Behaviour:
- Reset (async, active-high): state=IDLE, all outputs 0, rr_ptr=0, gap counter 0, lock_owner none.
- States: IDLE -> ISSUE -> WAIT -> DONE -> GAP -> IDLE.
- IDLE, grant selection:
  - If lock_owner is valid and its req=1, grant it.
  - Otherwise grant the first set req bit searching from rr_ptr upward, wrapping.
  - On a grant, latch that requester's operands into mst_*, set gnt one-hot, go to ISSUE.
  - No req: stay in IDLE.
- ISSUE:
  - If mst_busy=0: mst_start=1 for exactly one clock, go to WAIT.
  - Else hold; mst_start is never asserted while mst_busy=1.
- WAIT:
  - On mst_done: capture mst_rdata into rdata and mst_nack into nack, go to DONE.
- DONE:
  - req_done[owner]=1 for one clock; rdata/nack/err valid this clock and held until the next DONE.
  - rr_ptr = owner+1, mod NUM_REQ.
  - If lock[owner]=1, lock_owner=owner; else clear lock_owner.
  - Go to GAP, or straight to IDLE when I2C_TXN_DELAY=0.
- GAP:
  - Count I2C_TXN_DELAY clocks, then IDLE.
  - gnt stays asserted through GAP only if lock_owner is valid; otherwise gnt=0 from GAP entry.
- Latency: req rises at edge N -> gnt at N+1 -> mst_start at N+2 (mst_busy=0) -> req_done one clock after mst_done.
- Requesters hold req and operands stable until req_done.
  - req dropped before grant: no transaction.
  - req dropped after grant: the transaction completes and req_done still pulses.
- Locked owner drops req while in GAP: lock released at IDLE and normal round-robin resumes.
- mst_done in any state other than WAIT is ignored.
- Simultaneous requests are resolved in a single clock; exactly one gnt bit, never more.
- Reset mid-transaction returns to IDLE immediately; no req_done and no mst_abort are issued.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT-state counter starts at mst_start.
  - On reaching TIMEOUT_CYCLES without mst_done: mst_abort=1 for one clock, go to DONE with err=1, nack=0, rdata=0.
  - err clears on the next normal completion.
- Undefined: no counter; err and mst_abort tied 0; WAIT waits indefinitely.

Test Plan:
- Single write: req[0] with slave 7'h39, reg 8'h41, wdata 8'h10 -> gnt=3'b001 next clock, one mst_start with those values, req_done[0] one clock after mst_done, nack=0.
- Read: req[1], rw=1, reg 8'h9A, master returns 8'h03 -> rdata=8'h03 on req_done[1]; next start no earlier than 20 clocks later.
- Contention: req=3'b111 held -> grant order 0,1,2,0 with exactly one gnt bit set at any time.
- Lock: req=3'b011, lock[0]=1 for two transactions -> requester 0 served twice consecutively, then requester 1.
- Busy/NACK: mst_busy=1 during ISSUE for 5 clocks -> mst_start delayed until busy=0; mst_nack=1 -> nack=1 with req_done.
- Timeout (macro on, TIMEOUT_CYCLES=50, no mst_done) -> mst_abort at 50 clocks after start, req_done with err=1; reset asserted mid-WAIT -> all outputs 0 asynchronously.
